// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel shifter family (left and right shifters).
package barrel_pkg;

    localparam int BARREL_WIDTH = 32;
    localparam int BARREL_SHW   = 5;

    typedef enum logic [1:0] {
        SH_LOGICAL = 2'd0,
        SH_ARITH   = 2'd1,
        SH_ROTATE  = 2'd2
    } shmode_t;

    // Rotate wins over arith when both are requested.
    function automatic shmode_t decode_mode(input logic rot, input logic arith);
        if (rot)
            return SH_ROTATE;
        if (arith)
            return SH_ARITH;
        return SH_LOGICAL;
    endfunction

endpackage

// File: rtl/barrel_rshift_stage.sv
// One pipeline stage of the right barrel shifter: conditional shift by 2^K
// with fill selection, plus its valid register and ready term.
module barrel_rshift_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = BARREL_WIDTH,
    parameter int SHW   = BARREL_SHW,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev_v,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_shift,
    input  shmode_t          prev_mode,
    input  logic             prev_sign,
    input  logic             next_rdy,
    output logic             rdy,
    output logic             v,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   shift,
    output shmode_t          mode,
    output logic             sign
);

    localparam int S = 1 << K;

    logic             fill_bit;
    logic [WIDTH-1:0] shifted;

    // Shift the incoming word by 2^K when this stage's amount bit is set.
    always_comb begin
        fill_bit = (prev_mode == SH_ARITH) && prev_sign;
        shifted  = prev_data;
        if (prev_shift[K]) begin
            if (prev_mode == SH_ROTATE)
                shifted = {prev_data[S-1:0], prev_data[WIDTH-1:S]};
            else
                shifted = {{S{fill_bit}}, prev_data[WIDTH-1:S]};
        end
    end

    // An empty stage can always take a word, so bubbles collapse.
    assign rdy = !v || next_rdy;

    // Load from the predecessor whenever this stage can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            v     <= 1'b0;
            data  <= '0;
            shift <= '0;
            mode  <= SH_LOGICAL;
            sign  <= 1'b0;
        end else if (rdy) begin
            v     <= prev_v;
            data  <= shifted;
            shift <= prev_shift;
            mode  <= prev_mode;
            sign  <= prev_sign;
        end
    end

endmodule

// File: rtl/barrel_rshift_pipe.sv
// Pipelined right barrel shifter (logical / arithmetic / rotate), one stage
// per shift-amount bit, valid/ready on both ends.
module barrel_rshift_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH = BARREL_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shift,
    input  logic             rot,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    // Index 0 is the input port side; index k+1 is the register of stage k.
    logic    [SHW:0]            vld_pipe;
    logic    [SHW:0][WIDTH-1:0] data_pipe;
    logic    [SHW:0][SHW-1:0]   shift_pipe;
    shmode_t [SHW:0]            mode_pipe;
    logic    [SHW:0]            sign_pipe;

    assign vld_pipe[0]   = in_valid;
    assign data_pipe[0]  = a;
    assign shift_pipe[0] = shift;
    assign mode_pipe[0]  = decode_mode(rot, arith);
    assign sign_pipe[0]  = a[WIDTH-1];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        // Ready is kept per stage so the backward chain stays a plain wire path.
        logic rdy;
        logic nxt_rdy;

        if (k == SHW - 1) begin : g_last
            assign nxt_rdy = out_ready;
        end else begin : g_mid
            assign nxt_rdy = g_stage[k+1].rdy;
        end

        barrel_rshift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_v     (vld_pipe[k]),
            .prev_data  (data_pipe[k]),
            .prev_shift (shift_pipe[k]),
            .prev_mode  (mode_pipe[k]),
            .prev_sign  (sign_pipe[k]),
            .next_rdy   (nxt_rdy),
            .rdy        (rdy),
            .v          (vld_pipe[k+1]),
            .data       (data_pipe[k+1]),
            .shift      (shift_pipe[k+1]),
            .mode       (mode_pipe[k+1]),
            .sign       (sign_pipe[k+1])
        );
    end

    assign in_ready  = g_stage[0].rdy && !rst;
    assign out_valid = vld_pipe[SHW];
    assign out       = data_pipe[SHW];

    // Side-band fields of the last stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{shift_pipe[SHW], mode_pipe[SHW], sign_pipe[SHW]};

endmodule
